// File: rtl/ecc_serial_loader_if.sv
// Operand-loader bus between the bit-serial operand source and the ECC core.
// Carries the serial mP/nP frame inputs, the core's acks, and the parallel
// operand sets with their valid flags and error pulses.
//   slave  : loader view (serial frames and acks in, parallel operands out)
//   master : source/core view (serial frames and acks out, operands in)
interface ecc_serial_loader_if #(
  parameter int unsigned BIT = 32
);
  // Serial frame inputs
  logic           i_m_P_valid;
  logic           i_nP_valid;
  logic           i_mode;
  logic           i_a;
  logic           i_b;
  logic           i_prime;
  logic           i_Px;
  logic           i_Py;
  logic           i_m;
  logic           i_nPx;
  logic           i_nPy;
  // Core handshake
  logic           i_mP_ack;
  logic           i_nP_ack;
  // Parallel operand outputs
  logic [1:0]     o_mode;
  logic [BIT-1:0] o_a;
  logic [BIT-1:0] o_b;
  logic [BIT-1:0] o_prime;
  logic [BIT-1:0] o_Px;
  logic [BIT-1:0] o_Py;
  logic [BIT-1:0] o_m;
  logic [BIT-1:0] o_nPx;
  logic [BIT-1:0] o_nPy;
  logic           o_mP_valid;
  logic           o_nP_valid;
  logic           o_frame_err;
  logic           o_overrun;
  logic           o_range_err;

  modport slave (
    input  i_m_P_valid, i_nP_valid, i_mode, i_a, i_b, i_prime, i_Px, i_Py, i_m,
    input  i_nPx, i_nPy, i_mP_ack, i_nP_ack,
    output o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy,
    output o_mP_valid, o_nP_valid, o_frame_err, o_overrun, o_range_err
  );

  modport master (
    output i_m_P_valid, i_nP_valid, i_mode, i_a, i_b, i_prime, i_Px, i_Py, i_m,
    output i_nPx, i_nPy, i_mP_ack, i_nP_ack,
    input  o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy,
    input  o_mP_valid, o_nP_valid, o_frame_err, o_overrun, o_range_err
  );
endinterface

// File: rtl/ecc_serial_loader.sv
// ecc_serial_loader: deserializes MSB-first bit-serial ECC operand frames into
// parallel BIT-wide registers and offers them to the scalar-multiplication core
// through a valid/ack handshake.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ecc_serial_loader_if.slave
//         mP channel: 2-bit mode preamble then a, b, prime, Px, Py, m (BIT bits)
//         nP channel: nPx, nPy (BIT bits, no preamble)
//         o_frame_err / o_overrun: one-cycle pulses, OR of both channels
//         o_range_err: operand-not-reduced flag
// Build option: define ECC_LOADER_RANGE_CHECK_EN to add a register stage after
// each mP latch that checks a, b, Px, Py < prime and prime >= 3; mP valid then
// rises 2 cycles after the last bit instead of 1. Without it o_range_err is 0.
module ecc_serial_loader #(
  parameter int unsigned BIT = 32
) (
  input logic                clk,
  input logic                rst,
  ecc_serial_loader_if.slave bus
);

  localparam int unsigned      CntW    = $clog2(BIT + 1);
  localparam logic [CntW-1:0]  LastCnt = CntW'(BIT - 1);

  // MpMode1 is the IDLE cycle that samples mode[1]; it is never resident.
  typedef enum logic [2:0] {MpIdle, MpMode1, MpMode0, MpData, MpWaitLow} mp_state_e;
  typedef enum logic [1:0] {NpIdle, NpData, NpWaitLow} np_state_e;

  // ---------------------------------------------------------------- mP channel
  mp_state_e       mp_state_q, mp_state_d;
  logic [CntW-1:0] mp_cnt_q, mp_cnt_d;
  logic            mp_start, mp_mode1_en, mp_mode0_en, mp_shift, mp_done, mp_trunc;
  logic [1:0]      mode_sh_q;
  logic [BIT-1:0]  a_sh_q, b_sh_q, prime_sh_q, px_sh_q, py_sh_q, m_sh_q;
  logic            mp_done_q;
  logic [1:0]      mode_q;
  logic [BIT-1:0]  a_q, b_q, prime_q, px_q, py_q, m_q;
  logic            mp_set;
  logic            mp_valid_q, mp_valid_d;
  logic            mp_ovr;

  always_comb begin
    mp_state_d  = mp_state_q;
    mp_cnt_d    = mp_cnt_q;
    mp_start    = 1'b0;
    mp_mode1_en = 1'b0;
    mp_mode0_en = 1'b0;
    mp_shift    = 1'b0;
    mp_done     = 1'b0;
    mp_trunc    = 1'b0;
    unique case (mp_state_q)
      MpIdle: begin
        if (bus.i_m_P_valid) begin
          mp_start    = 1'b1;
          mp_mode1_en = 1'b1;
          mp_state_d  = MpMode0;
        end
      end
      MpMode1: mp_state_d = MpIdle;
      MpMode0: begin
        if (bus.i_m_P_valid) begin
          mp_mode0_en = 1'b1;
          mp_cnt_d    = '0;
          mp_state_d  = MpData;
        end else begin
          mp_trunc   = 1'b1;
          mp_state_d = MpIdle;
        end
      end
      MpData: begin
        if (bus.i_m_P_valid) begin
          mp_shift = 1'b1;
          mp_cnt_d = mp_cnt_q + CntW'(1);
          if (mp_cnt_q == LastCnt) begin
            mp_done    = 1'b1;
            mp_state_d = MpWaitLow;
          end
        end else begin
          mp_trunc   = 1'b1;
          mp_state_d = MpIdle;
        end
      end
      MpWaitLow: begin
        if (!bus.i_m_P_valid) mp_state_d = MpIdle;
      end
      default: mp_state_d = MpIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mp_state_q <= MpIdle;
      mp_cnt_q   <= '0;
      mode_sh_q  <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      prime_sh_q <= '0;
      px_sh_q    <= '0;
      py_sh_q    <= '0;
      m_sh_q     <= '0;
      mp_done_q  <= 1'b0;
      mode_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prime_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      m_q        <= '0;
      mp_valid_q <= 1'b0;
    end else begin
      mp_state_q <= mp_state_d;
      mp_cnt_q   <= mp_cnt_d;
      if (mp_mode1_en) mode_sh_q[1] <= bus.i_mode;
      if (mp_mode0_en) mode_sh_q[0] <= bus.i_mode;
      if (mp_shift) begin
        a_sh_q     <= {a_sh_q[BIT-2:0], bus.i_a};
        b_sh_q     <= {b_sh_q[BIT-2:0], bus.i_b};
        prime_sh_q <= {prime_sh_q[BIT-2:0], bus.i_prime};
        px_sh_q    <= {px_sh_q[BIT-2:0], bus.i_Px};
        py_sh_q    <= {py_sh_q[BIT-2:0], bus.i_Py};
        m_sh_q     <= {m_sh_q[BIT-2:0], bus.i_m};
      end
      mp_done_q <= mp_done;
      // Shadows are stable here: a new frame cannot shift before WAIT_LOW exits.
      if (mp_done_q) begin
        mode_q  <= mode_sh_q;
        a_q     <= a_sh_q;
        b_q     <= b_sh_q;
        prime_q <= prime_sh_q;
        px_q    <= px_sh_q;
        py_q    <= py_sh_q;
        m_q     <= m_sh_q;
      end
      mp_valid_q <= mp_valid_d;
    end
  end

  // Ack in the start cycle counts as a normal ack, so no overrun is flagged.
  always_comb begin
    mp_valid_d = mp_valid_q;
    mp_ovr     = 1'b0;
    if (mp_valid_q && bus.i_mP_ack) mp_valid_d = 1'b0;
    if (mp_start && mp_valid_q) begin
      mp_valid_d = 1'b0;
      mp_ovr     = !bus.i_mP_ack;
    end
    if (mp_set) mp_valid_d = 1'b1;
  end

`ifdef ECC_LOADER_RANGE_CHECK_EN
  logic mp_rng_q;
  logic range_hit;
  logic range_err_q, range_err_d;

  // Evaluated on the freshly latched output registers, one cycle after the latch.
  assign range_hit = (a_q >= prime_q) | (b_q >= prime_q) | (px_q >= prime_q) |
                     (py_q >= prime_q) | (prime_q < BIT'(3));
  assign mp_set      = mp_rng_q;
  assign range_err_d = mp_set ? range_hit : (mp_valid_d & range_err_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mp_rng_q    <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      mp_rng_q    <= mp_done_q;
      range_err_q <= range_err_d;
    end
  end

  assign bus.o_range_err = range_err_q;
`else
  assign mp_set          = mp_done_q;
  assign bus.o_range_err = 1'b0;
`endif

  // ---------------------------------------------------------------- nP channel
  np_state_e       np_state_q, np_state_d;
  logic [CntW-1:0] np_cnt_q, np_cnt_d;
  logic            np_start, np_shift, np_done, np_trunc;
  logic [BIT-1:0]  npx_sh_q, npy_sh_q;
  logic            np_done_q;
  logic [BIT-1:0]  npx_q, npy_q;
  logic            np_valid_q, np_valid_d;
  logic            np_ovr;

  // No preamble: the first valid cycle already carries data bit BIT-1.
  always_comb begin
    np_state_d = np_state_q;
    np_cnt_d   = np_cnt_q;
    np_start   = 1'b0;
    np_shift   = 1'b0;
    np_done    = 1'b0;
    np_trunc   = 1'b0;
    unique case (np_state_q)
      NpIdle: begin
        if (bus.i_nP_valid) begin
          np_start   = 1'b1;
          np_shift   = 1'b1;
          np_cnt_d   = CntW'(1);
          np_state_d = NpData;
        end
      end
      NpData: begin
        if (bus.i_nP_valid) begin
          np_shift = 1'b1;
          np_cnt_d = np_cnt_q + CntW'(1);
          if (np_cnt_q == LastCnt) begin
            np_done    = 1'b1;
            np_state_d = NpWaitLow;
          end
        end else begin
          np_trunc   = 1'b1;
          np_state_d = NpIdle;
        end
      end
      NpWaitLow: begin
        if (!bus.i_nP_valid) np_state_d = NpIdle;
      end
      default: np_state_d = NpIdle;
    endcase
  end

  always_comb begin
    np_valid_d = np_valid_q;
    np_ovr     = 1'b0;
    if (np_valid_q && bus.i_nP_ack) np_valid_d = 1'b0;
    if (np_start && np_valid_q) begin
      np_valid_d = 1'b0;
      np_ovr     = !bus.i_nP_ack;
    end
    if (np_done_q) np_valid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      np_state_q <= NpIdle;
      np_cnt_q   <= '0;
      npx_sh_q   <= '0;
      npy_sh_q   <= '0;
      np_done_q  <= 1'b0;
      npx_q      <= '0;
      npy_q      <= '0;
      np_valid_q <= 1'b0;
    end else begin
      np_state_q <= np_state_d;
      np_cnt_q   <= np_cnt_d;
      if (np_shift) begin
        npx_sh_q <= {npx_sh_q[BIT-2:0], bus.i_nPx};
        npy_sh_q <= {npy_sh_q[BIT-2:0], bus.i_nPy};
      end
      np_done_q <= np_done;
      if (np_done_q) begin
        npx_q <= npx_sh_q;
        npy_q <= npy_sh_q;
      end
      np_valid_q <= np_valid_d;
    end
  end

  // ---------------------------------------------------------------- shared pulses
  logic frame_err_q, overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= mp_trunc | np_trunc;
      overrun_q   <= mp_ovr | np_ovr;
    end
  end

  assign bus.o_mode      = mode_q;
  assign bus.o_a         = a_q;
  assign bus.o_b         = b_q;
  assign bus.o_prime     = prime_q;
  assign bus.o_Px        = px_q;
  assign bus.o_Py        = py_q;
  assign bus.o_m         = m_q;
  assign bus.o_nPx       = npx_q;
  assign bus.o_nPy       = npy_q;
  assign bus.o_mP_valid  = mp_valid_q;
  assign bus.o_nP_valid  = np_valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_ecc_serial_loader.sv
module tb_ecc_serial_loader;
  localparam int unsigned BIT = 32;
`ifdef ECC_LOADER_RANGE_CHECK_EN
  localparam int Lat     = 2;
  localparam bit RangeEn = 1'b1;
`else
  localparam int Lat     = 1;
  localparam bit RangeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_serial_loader_if #(.BIT(BIT)) bus ();
  ecc_serial_loader #(.BIT(BIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]     mode;
    logic [BIT-1:0] a, b, p, px, py, m;
    logic           rng;
  } mp_t;
  typedef struct {
    logic [BIT-1:0] x, y;
  } np_t;

  mp_t mp_sb[$];
  np_t np_sb[$];
  mp_t last_mp;
  np_t last_np;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  always @(negedge clk) begin
    if (bus.o_frame_err === 1'b1) fe_cnt++;
    if (bus.o_overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [BIT-1:0] obs, input logic [BIT-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_m_P_valid = 1'b0; bus.i_nP_valid = 1'b0; bus.i_mode = 1'b0;
    bus.i_a = 1'b0; bus.i_b = 1'b0; bus.i_prime = 1'b0; bus.i_Px = 1'b0;
    bus.i_Py = 1'b0; bus.i_m = 1'b0; bus.i_nPx = 1'b0; bus.i_nPy = 1'b0;
    bus.i_mP_ack = 1'b0; bus.i_nP_ack = 1'b0;
  endtask

  task automatic set_mp_bits(input logic [BIT-1:0] a, b, p, px, py, m, input int i);
    bus.i_a = a[BIT-1-i]; bus.i_b = b[BIT-1-i]; bus.i_prime = p[BIT-1-i];
    bus.i_Px = px[BIT-1-i]; bus.i_Py = py[BIT-1-i]; bus.i_m = m[BIT-1-i];
  endtask

  task automatic cmp_mp(input mp_t e);
    chk("mp_mode", bus.o_mode, e.mode);
    chk("mp_a", bus.o_a, e.a);
    chk("mp_b", bus.o_b, e.b);
    chk("mp_prime", bus.o_prime, e.p);
    chk("mp_px", bus.o_Px, e.px);
    chk("mp_py", bus.o_Py, e.py);
    chk("mp_m", bus.o_m, e.m);
    chk("mp_range_err", bus.o_range_err, e.rng);
  endtask

  // Drives one mP frame: preamble, ndata bits, then extra ignored bits.
  task automatic send_mp(input logic [1:0] mode, input logic [BIT-1:0] a, b, p, px, py, m,
                         input int ndata, input int extra, input bit ack_start,
                         input bit exp_ovr);
    mp_t e;
    e.mode = mode; e.a = a; e.b = b; e.p = p; e.px = px; e.py = py; e.m = m;
    e.rng = RangeEn && ((a >= p) || (b >= p) || (px >= p) || (py >= p) || (p < 3));
    if (ndata == BIT) mp_sb.push_back(e);
    bus.i_m_P_valid = 1'b1; bus.i_mode = mode[1]; bus.i_mP_ack = ack_start;
    tick();
    bus.i_mP_ack = 1'b0;
    chk("mp_overrun", bus.o_overrun, exp_ovr);
    chk("mp_valid_at_start", bus.o_mP_valid, 1'b0);
    if (exp_ovr) chk("mp_ovr_hold_a", bus.o_a, last_mp.a);
    bus.i_mode = mode[0];
    tick();
    for (int i = 0; i < ndata; i++) begin
      set_mp_bits(a, b, p, px, py, m, i);
      tick();
    end
    if (ndata != BIT) begin
      bus.i_m_P_valid = 1'b0;
      tick();
      chk("mp_frame_err", bus.o_frame_err, 1'b1);
      tick();
      chk("mp_frame_err_end", bus.o_frame_err, 1'b0);
      chk("mp_trunc_valid", bus.o_mP_valid, 1'b0);
      chk("mp_trunc_hold_px", bus.o_Px, last_mp.px);
      return;
    end
    chk("mp_lat_early", bus.o_mP_valid, 1'b0);
    for (int c = 1; c <= Lat; c++) begin
      bus.i_m_P_valid = (c <= extra);
      set_mp_bits($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0);
      tick();
      if (c < Lat) begin
        chk("mp_lat_mid", bus.o_mP_valid, 1'b0);
      end else begin
        chk("mp_lat_rise", bus.o_mP_valid, 1'b1);
        if (mp_sb.size() == 0) begin
          checks++; errors++;
          $error("FAIL mp_scoreboard observed=empty expected=entry");
        end else begin
          last_mp = mp_sb.pop_front();
          cmp_mp(last_mp);
        end
      end
    end
    for (int c = Lat + 1; c <= extra; c++) begin
      bus.i_m_P_valid = 1'b1;
      set_mp_bits($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0);
      tick();
    end
    bus.i_m_P_valid = 1'b0;
    set_mp_bits('0, '0, '0, '0, '0, '0, 0);
    tick();
    chk("mp_extra_ignored_a", bus.o_a, last_mp.a);
    chk("mp_extra_ignored_m", bus.o_m, last_mp.m);
  endtask

  task automatic send_np(input logic [BIT-1:0] x, y, input int ndata, input bit ack_start,
                         input bit exp_ovr);
    np_t e;
    e.x = x; e.y = y;
    if (ndata == BIT) np_sb.push_back(e);
    bus.i_nP_valid = 1'b1;
    for (int i = 0; i < ndata; i++) begin
      bus.i_nPx = x[BIT-1-i]; bus.i_nPy = y[BIT-1-i];
      bus.i_nP_ack = (i == 0) && ack_start;
      tick();
      bus.i_nP_ack = 1'b0;
      if (i == 0) begin
        chk("np_overrun", bus.o_overrun, exp_ovr);
        chk("np_valid_at_start", bus.o_nP_valid, 1'b0);
        if (exp_ovr) chk("np_ovr_hold_x", bus.o_nPx, last_np.x);
      end
    end
    bus.i_nP_valid = 1'b0; bus.i_nPx = 1'b0; bus.i_nPy = 1'b0;
    if (ndata != BIT) begin
      tick();
      chk("np_frame_err", bus.o_frame_err, 1'b1);
      tick();
      chk("np_trunc_valid", bus.o_nP_valid, 1'b0);
      return;
    end
    chk("np_lat_early", bus.o_nP_valid, 1'b0);
    tick();
    chk("np_lat_rise", bus.o_nP_valid, 1'b1);
    if (np_sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL np_scoreboard observed=empty expected=entry");
    end else begin
      last_np = np_sb.pop_front();
      chk("np_x", bus.o_nPx, last_np.x);
      chk("np_y", bus.o_nPy, last_np.y);
    end
  endtask

  task automatic ack_mp(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("mp_valid_hold", bus.o_mP_valid, 1'b1);
      chk("mp_range_hold", bus.o_range_err, last_mp.rng);
    end
    bus.i_mP_ack = 1'b1;
    tick();
    bus.i_mP_ack = 1'b0;
    chk("mp_valid_clr", bus.o_mP_valid, 1'b0);
    chk("mp_range_clr", bus.o_range_err, 1'b0);
  endtask

  task automatic ack_np(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("np_valid_hold", bus.o_nP_valid, 1'b1);
    end
    bus.i_nP_ack = 1'b1;
    tick();
    bus.i_nP_ack = 1'b0;
    chk("np_valid_clr", bus.o_nP_valid, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mode"}, bus.o_mode, '0);
    chk({tag, "_a"}, bus.o_a, '0);
    chk({tag, "_prime"}, bus.o_prime, '0);
    chk({tag, "_px"}, bus.o_Px, '0);
    chk({tag, "_npx"}, bus.o_nPx, '0);
    chk({tag, "_mp_valid"}, bus.o_mP_valid, '0);
    chk({tag, "_np_valid"}, bus.o_nP_valid, '0);
    chk({tag, "_frame_err"}, bus.o_frame_err, '0);
    chk({tag, "_overrun"}, bus.o_overrun, '0);
    chk({tag, "_range_err"}, bus.o_range_err, '0);
  endtask

  initial begin
    int fe_snap;
    clear_inputs();
    last_mp = '{mode: '0, a: '0, b: '0, p: '0, px: '0, py: '0, m: '0, rng: 1'b0};
    last_np = '{x: '0, y: '0};
    rst = 1'b1;
    tick(); tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal mP frame.
    send_mp(2'b10, 32'h00000003, 32'h00000007, 32'hFFFFFFFB, 32'h12345678, 32'h0F0F0F0F,
            32'h80000001, BIT, 0, 1'b0, 1'b0);
    ack_mp(3);

    // nP frame 5 cycles later; mP outputs untouched.
    repeat (5) tick();
    send_np(32'hDEADBEEF, 32'h00000001, BIT, 1'b0, 1'b0);
    chk("np_mp_untouched_a", bus.o_a, last_mp.a);
    chk("np_mp_untouched_valid", bus.o_mP_valid, 1'b0);
    ack_np(2);

    // Truncated mP frame after 10 data bits, then a clean full frame.
    send_mp(2'b01, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 10, 0,
            1'b0, 1'b0);
    send_mp(2'b01, 32'h11111111, 32'h22222222, 32'hF0000001, 32'h33333333, 32'h44444444,
            32'hA5A5A5A5, BIT, 0, 1'b0, 1'b0);
    ack_mp(1);

    // Overrun: new mP frame over an unacked set, then ack on the start cycle.
    send_mp(2'b11, 32'h01020304, 32'h05060708, 32'hFFFFFFF1, 32'h0A0B0C0D, 32'h0E0F1011,
            32'h12131415, BIT, 0, 1'b0, 1'b0);
    send_mp(2'b00, 32'hCAFEF00D, 32'h00000002, 32'hFFFFFFFF, 32'h00000004, 32'h00000005,
            32'h00000006, BIT, 0, 1'b0, 1'b1);
    send_mp(2'b10, 32'h00000009, 32'h0000000A, 32'h7FFFFFFF, 32'h0000000B, 32'h0000000C,
            32'h0000000D, BIT, 0, 1'b1, 1'b0);
    ack_mp(1);

    // Same on the nP channel.
    send_np(32'h13579BDF, 32'h2468ACE0, BIT, 1'b0, 1'b0);
    send_np(32'h0000FFFF, 32'hFFFF0000, BIT, 1'b0, 1'b1);
    send_np(32'h89ABCDEF, 32'h76543210, BIT, 1'b1, 1'b0);
    ack_np(1);

    // Reset at data bit 16 of an mP frame.
    fe_snap = fe_cnt;
    bus.i_m_P_valid = 1'b1; bus.i_mode = 1'b1;
    tick();
    bus.i_mode = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      set_mp_bits(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFF, i);
      tick();
    end
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    bus.i_m_P_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("midrst_no_frame_err", fe_cnt, fe_snap);
    chk("midrst_valid_low", bus.o_mP_valid, 1'b0);
    last_mp = '{mode: '0, a: '0, b: '0, p: '0, px: '0, py: '0, m: '0, rng: 1'b0};
    last_np = '{x: '0, y: '0};
    send_mp(2'b01, 32'h0BADF00D, 32'h00C0FFEE, 32'hFFFFFFC5, 32'h00000010, 32'h00000020,
            32'h00000030, BIT, 3, 1'b0, 1'b0);
    ack_mp(1);

    // Operand not reduced, then reduced.
    send_mp(2'b10, 32'h00000003, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h0F0F0F0F,
            32'h80000001, BIT, 0, 1'b0, 1'b0);
    ack_mp(2);
    send_mp(2'b10, 32'h00000003, 32'h00000007, 32'hFFFFFFFB, 32'h00000005, 32'h0F0F0F0F,
            32'h80000001, BIT, 0, 1'b0, 1'b0);
    ack_mp(2);

    repeat (3) tick();
    chk("total_frame_err_pulses", fe_cnt, 1);
    chk("total_overrun_pulses", ov_cnt, 2);
    chk("mp_sb_drained", mp_sb.size(), 0);
    chk("np_sb_drained", np_sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
